// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// regfile_mp_pkg : shared constants and helpers for the multi-port regfile
// Revision: 1.0
// ============================================================================
package regfile_mp_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    localparam int MIPS_ZERO = 0;
    localparam int MIPS_RA   = 31;

    // Never returns less than 1 so a single-entry file still has an address bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_rd_port.sv
`default_nettype none
// ============================================================================
// regfile_mp_rd_port : one combinational read port with bypass and masking
// Revision: 1.0
// ============================================================================
module regfile_mp_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = clog2(NUM_REGS)
)(
    input  logic [ADDR_W-1:0]          rd_addr_i,
    input  logic [NUM_REGS*DATA_W-1:0] mem_i,
    input  logic [NUM_REGS-1:0]        pend_i,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       rd_busy_o
);

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        if ((int'(rd_addr_i) < NUM_REGS) && !((ZERO_REG != 0) && (rd_addr_i == '0))) begin
            rd_data_o = mem_i[int'(rd_addr_i)*DATA_W +: DATA_W];
            rd_busy_o = pend_i[rd_addr_i];
            // Ascending scan lets the highest-index matching write take the port.
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == rd_addr_i)) begin
                        rd_data_o = wr_data_i[w*DATA_W +: DATA_W];
                        rd_busy_o = 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : multi-port register file with pending scoreboard and bypass
// Revision: 1.0
// ============================================================================
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = clog2(NUM_REGS)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     alloc_en_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i
);

    logic [DATA_W-1:0]          mem_q [NUM_REGS];
    logic [DATA_W-1:0]          mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]        pend_q;
    logic [NUM_REGS-1:0]        pend_d;
    logic [NUM_REGS*DATA_W-1:0] mem_flat;
    logic [NUM_WR-1:0]          byp_en;

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Writes applied in port order so the highest index wins; alloc last so it beats the clear.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && writable(wr_addr_i[w*ADDR_W +: ADDR_W])) begin
                mem_d[wr_addr_i[w*ADDR_W +: ADDR_W]]  = wr_data_i[w*DATA_W +: DATA_W];
                pend_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (alloc_en_i && writable(alloc_addr_i)) begin
            pend_d[alloc_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
            assign mem_flat[i*DATA_W +: DATA_W] = mem_q[i];
        end
    endgenerate

    // Bypass must not leak write data onto the read ports while reset holds.
    assign byp_en = wr_en_i & {NUM_WR{rst_n}};

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            regfile_mp_rd_port #(
                .DATA_W   (DATA_W),
                .NUM_REGS (NUM_REGS),
                .NUM_WR   (NUM_WR),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS),
                .ADDR_W   (ADDR_W)
            ) u_rd_port (
                .rd_addr_i (rd_addr_i[p*ADDR_W +: ADDR_W]),
                .mem_i     (mem_flat),
                .pend_i    (pend_q),
                .wr_en_i   (byp_en),
                .wr_addr_i (wr_addr_i),
                .wr_data_i (wr_data_i),
                .rd_data_o (rd_data_o[p*DATA_W +: DATA_W]),
                .rd_busy_o (rd_busy_o[p])
            );
        end
    endgenerate

endmodule
`default_nettype wire
